// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline latch.
//   pipe_state_e   : occupancy state of a latch (EMPTY, ONE, TWO)
//   PIPE_NOP_INSTR : instruction encoding used to build a NOP_VALUE bubble
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_latch_elastic_register_w.sv
// register_w: WIDTH-bit register, falling-edge clocked, with load enable and
// asynchronous clear to a parameterised value.
//   clock  : clock, state updates on the falling edge
//   clear  : asynchronous, active-high; forces q to CLEAR_VALUE
//   enable : load d on the falling edge
//   d      : next value
//   q      : stored value
module register_w #(
  parameter int unsigned         WIDTH       = 32,
  parameter logic [WIDTH-1:0]    CLEAR_VALUE = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(negedge clock or posedge clear) begin
    if (clear) begin
      q <= CLEAR_VALUE;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_latch_elastic.sv
// pipe_latch_elastic: elastic stage latch with valid/ready handshake and a
// one-entry skid, so upstream keeps moving one extra cycle after a stall.
// Optional feature macro: PIPE_LATCH_STALL_COUNT_EN adds the stall_cycles port.
//   clock        : stage clock, all state changes on the falling edge
//   reset        : asynchronous, active-high
//   in_valid/in_ready/in_data    : upstream handshake (in_ready is registered)
//   out_valid/out_ready/out_data : downstream handshake (out_data = NOP_VALUE when idle)
//   flush        : synchronous kill of every held entry
//   occupancy    : number of held entries, 0..2
//   stall_cycles : saturating count of cycles with out_valid & ~out_ready
//
// state | meaning
// EMPTY | no entries held
// ONE   | main entry valid
// TWO   | main and skid entries valid, upstream blocked
module pipe_latch_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
`ifdef PIPE_LATCH_STALL_COUNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  pipe_state_e      state_q, state_d;
  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_d;
  logic             accept, consume;

  assign accept  = in_valid & in_ready;
  assign consume = main_valid & out_ready;

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Data registers are written only when an entry changes; an emptied entry
  // is reloaded with NOP_VALUE so out_data needs no output mux.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = NOP_VALUE;
    skid_d  = NOP_VALUE;
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b1;
      skid_en = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_en = 1'b1;
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (consume && accept) begin
            main_en = 1'b1;
            main_d  = in_data;
          end else if (consume) begin
            main_en = 1'b1;
            state_d = EMPTY;
          end else if (accept) begin
            skid_en = 1'b1;
            skid_d  = in_data;
            state_d = TWO;
          end
        end
        TWO: begin
          if (consume) begin
            main_en = 1'b1;
            main_d  = skid_data;
            skid_en = 1'b1;
            state_d = ONE;
          end
        end
        default: begin
          main_en = 1'b1;
          skid_en = 1'b1;
          state_d = EMPTY;
        end
      endcase
    end
  end

  register_w #(.WIDTH(WIDTH), .CLEAR_VALUE(NOP_VALUE)) u_main_data (
    .clock(clock), .clear(reset), .enable(main_en), .d(main_d), .q(main_data)
  );

  register_w #(.WIDTH(WIDTH), .CLEAR_VALUE(NOP_VALUE)) u_skid_data (
    .clock(clock), .clear(reset), .enable(skid_en), .d(skid_d), .q(skid_data)
  );

  register_w #(.WIDTH(1), .CLEAR_VALUE(1'b0)) u_main_valid (
    .clock(clock), .clear(reset), .enable(1'b1),
    .d(state_d != EMPTY), .q(main_valid)
  );

  register_w #(.WIDTH(1), .CLEAR_VALUE(1'b0)) u_skid_valid (
    .clock(clock), .clear(reset), .enable(1'b1),
    .d(state_d == TWO), .q(skid_valid)
  );

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign in_ready  = ~skid_valid;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

`ifdef PIPE_LATCH_STALL_COUNT_EN
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'h0000;
    end else if (main_valid && !out_ready && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`else
  // Stall counter not built.
`endif

endmodule

// File: tb/tb_pipe_latch_elastic.sv
// Directed self-checking bench for pipe_latch_elastic.
// Inputs change and outputs are sampled 1 time unit after each falling edge.
module tb_pipe_latch_elastic;
  import pipe_pkg::*;

  localparam int unsigned      W   = 64;
  localparam logic [W-1:0]     NOP = {32'h0000_0013, PIPE_NOP_INSTR};

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flush;
  logic [1:0]   occupancy;
`ifdef PIPE_LATCH_STALL_COUNT_EN
  logic [15:0]  stall_cycles;
`endif

  int tests_run;
  int tests_failed;

  pipe_latch_elastic #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy)
`ifdef PIPE_LATCH_STALL_COUNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== NOP || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got v=%b d=%h rdy=%b occ=%0d, want v=0 d=%h rdy=1 occ=0",
               out_valid, out_data, in_ready, occupancy, NOP);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      cyc();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== W'(i) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_%0d: got v=%b d=%h occ=%0d rdy=%b, want v=1 d=%0d occ=1 rdy=1",
                 i, out_valid, out_data, occupancy, in_ready, i);
      end
    end
    in_valid = 1'b0;
    in_data  = 'x;
    cyc();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== NOP || occupancy !== 2'd0) begin
      tests_failed++;
      $display("FAIL stream_drain: got v=%b d=%h occ=%0d, want v=0 d=%h occ=0",
               out_valid, out_data, occupancy, NOP);
    end
  endtask

  task automatic test_skid();
    in_valid = 1'b1; in_data = W'(5); out_ready = 1'b0;
    cyc();
    tests_run++;
    if (out_data !== W'(5) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL skid_one: got d=%h occ=%0d rdy=%b, want d=5 occ=1 rdy=1", out_data, occupancy, in_ready);
    end
    in_data = W'(6);
    cyc();
    tests_run++;
    if (out_data !== W'(5) || occupancy !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL skid_two: got d=%h occ=%0d rdy=%b v=%b, want d=5 occ=2 rdy=0 v=1",
               out_data, occupancy, in_ready, out_valid);
    end
    // in_ready is low, so payload 7 must not be taken while stalled
    in_data = W'(7);
    cyc();
    tests_run++;
    if (out_data !== W'(5) || occupancy !== 2'd2) begin
      tests_failed++;
      $display("FAIL skid_hold: got d=%h occ=%0d, want d=5 occ=2", out_data, occupancy);
    end
    in_valid = 1'b0; in_data = 'x; out_ready = 1'b1;
    cyc();
    tests_run++;
    if (out_data !== W'(6) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL skid_release: got d=%h occ=%0d rdy=%b, want d=6 occ=1 rdy=1", out_data, occupancy, in_ready);
    end
    cyc();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== NOP || occupancy !== 2'd0) begin
      tests_failed++;
      $display("FAIL skid_empty: got v=%b d=%h occ=%0d, want v=0 d=%h occ=0", out_valid, out_data, occupancy, NOP);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = W'(32'h11); cyc();
    in_data = W'(32'h12); cyc();
    tests_run++;
    if (occupancy !== 2'd2) begin
      tests_failed++;
      $display("FAIL flush_fill: got occ=%0d, want 2", occupancy);
    end
    flush = 1'b1; in_data = W'(9);
    cyc();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== NOP || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_two: got v=%b d=%h occ=%0d rdy=%b, want v=0 d=%h occ=0 rdy=1",
               out_valid, out_data, occupancy, in_ready, NOP);
    end
    flush = 1'b0; in_valid = 1'b0; in_data = 'x; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests_run++;
      if (out_valid !== 1'b0 || out_data !== NOP) begin
        tests_failed++;
        $display("FAIL flush_no_ghost_%0d: got v=%b d=%h, want v=0 d=%h", i, out_valid, out_data, NOP);
      end
    end
    // flush in ONE with a simultaneous accept discards the new payload
    in_valid = 1'b1; in_data = W'(32'h21); out_ready = 1'b0; cyc();
    flush = 1'b1; in_data = W'(32'h22); out_ready = 1'b1; cyc();
    flush = 1'b0; in_valid = 1'b0; in_data = 'x;
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== NOP) begin
      tests_failed++;
      $display("FAIL flush_one: got v=%b d=%h occ=%0d, want v=0 d=%h occ=0", out_valid, out_data, occupancy, NOP);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = W'(32'h31); cyc();
    in_data = W'(32'h32); cyc();
    in_valid = 1'b0; in_data = 'x;
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== NOP || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b d=%h rdy=%b occ=%0d, want v=0 d=%h rdy=1 occ=0",
               out_valid, out_data, in_ready, occupancy, NOP);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    in_valid = 1'b1; in_data = W'(32'h33); out_ready = 1'b1;
    cyc();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== W'(32'h33) || occupancy !== 2'd1) begin
      tests_failed++;
      $display("FAIL reset_release: got v=%b d=%h occ=%0d, want v=1 d=33 occ=1", out_valid, out_data, occupancy);
    end
    in_valid = 1'b0; in_data = 'x;
    cyc();
  endtask

  task automatic test_x_input();
    in_valid = 1'b0; in_data = 'x; out_ready = 1'b1;
    cyc();
    tests_run++;
    if (out_data !== NOP || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL x_input: got v=%b d=%h, want v=0 d=%h", out_valid, out_data, NOP);
    end
  endtask

`ifdef PIPE_LATCH_STALL_COUNT_EN
  task automatic test_stall_count();
    reset = 1'b1; #1; reset = 1'b0;
    in_valid = 1'b1; in_data = W'(32'h44); out_ready = 1'b0;
    cyc();
    in_valid = 1'b0; in_data = 'x;
    repeat (10) cyc();
    tests_run++;
    if (stall_cycles !== 16'd10) begin
      tests_failed++;
      $display("FAIL stall_10: got %0d, want 10", stall_cycles);
    end
    flush = 1'b1; out_ready = 1'b1; cyc();
    flush = 1'b0;
    tests_run++;
    if (stall_cycles !== 16'd10) begin
      tests_failed++;
      $display("FAIL stall_after_flush: got %0d, want 10", stall_cycles);
    end
    in_valid = 1'b1; in_data = W'(32'h45); out_ready = 1'b0; cyc();
    in_valid = 1'b0; in_data = 'x;
    repeat (70000) @(negedge clock);
    #1;
    tests_run++;
    if (stall_cycles !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL stall_saturate: got %h, want ffff", stall_cycles);
    end
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = 'x; out_ready = 1'b0; flush = 1'b0;
    #3;
    test_reset();
    @(negedge clock);
    #1;
    reset = 1'b0;
    test_stream();
    test_skid();
    test_flush();
    test_async_reset();
    test_x_input();
`ifdef PIPE_LATCH_STALL_COUNT_EN
    test_stall_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
